// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle MIPS control FSM for the P-series datapath
// Moore outputs on state, with instr decode for the ALU op, extend mode and write-register select.
module mc_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic        pc_en,
    output logic        ir_en,
    output logic        mem_we,
    output logic        rf_we,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wd_sel,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  ALUOp,
    output logic [1:0]  ext_op,
    output logic [1:0]  npc_sel,
    output logic        illegal,
    output logic [3:0]  state
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WB   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t      state_q, state_d;
    logic [5:0]  op, funct;
    logic [2:0]  r_aluop;
    logic        r_legal;
    logic        unused_fields;

    assign op            = instr[31:26];
    assign funct         = instr[5:0];
    assign unused_fields = ^instr[25:6];
    assign state         = state_q;

    always_comb begin
        r_legal = 1'b1;
        case (funct)
            6'b100001: r_aluop = 3'b000;
            6'b100011: r_aluop = 3'b001;
            6'b100100: r_aluop = 3'b010;
            6'b100101: r_aluop = 3'b011;
            6'b000110: r_aluop = 3'b100;
            6'b000111: r_aluop = 3'b101;
            default: begin
                r_aluop = 3'b000;
                r_legal = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:       state_d = r_legal ? S_EXEC_R : S_FETCH;
                    OP_ORI, OP_LUI: state_d = S_EXEC_I;
                    OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                    OP_BEQ:         state_d = S_BRANCH;
                    OP_J:           state_d = S_JUMP;
                    default:        state_d = S_FETCH;
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
            S_MEM_ADDR: state_d = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = S_MEM_WB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Enables are gated by reset so an aborted instruction cannot commit a write.
    always_comb begin
        pc_en     = 1'b0;
        ir_en     = 1'b0;
        mem_we    = 1'b0;
        rf_we     = 1'b0;
        reg_dst   = 2'd0;
        wd_sel    = 2'd0;
        alu_src_a = 1'b0;
        alu_src_b = 2'd0;
        ALUOp     = 3'b000;
        ext_op    = 2'd0;
        npc_sel   = 2'd0;
        illegal   = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_en     = ~reset;
                pc_en     = ~reset;
                alu_src_b = 2'd1;
            end
            S_DECODE: begin
                alu_src_b = 2'd3;
                ext_op    = 2'd1;
                case (op)
                    OP_RTYPE: illegal = ~r_legal;
                    OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J: illegal = 1'b0;
                    default:  illegal = 1'b1;
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                ALUOp     = r_aluop;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                ALUOp     = 3'b011;
                ext_op    = (op == OP_LUI) ? 2'd2 : 2'd0;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                ext_op    = 2'd1;
            end
            S_MEM_WB: begin
                rf_we  = ~reset;
                wd_sel = 2'd1;
            end
            S_MEM_WR: mem_we = ~reset;
            S_ALU_WB: begin
                rf_we   = ~reset;
                reg_dst = (op == OP_RTYPE) ? 2'd1 : 2'd0;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                ALUOp     = 3'b001;
                npc_sel   = 2'd1;
                pc_en     = zero & ~reset;
            end
            S_JUMP: begin
                pc_en   = ~reset;
                npc_sel = 2'd2;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - scoreboard bench for mc_ctrl
// Per-cycle expected control words are queued per instruction and popped each cycle.
module tb_mc_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        zero;
    logic        pc_en, ir_en, mem_we, rf_we, alu_src_a, illegal;
    logic [1:0]  reg_dst, wd_sel, alu_src_b, ext_op, npc_sel;
    logic [2:0]  ALUOp;
    logic [3:0]  state;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_en, ir_en, mem_we, rf_we;
        logic [1:0] reg_dst, wd_sel;
        logic       a;
        logic [1:0] b;
        logic [2:0] aluop;
        logic [1:0] ext, npc;
        logic       ill;
    } ctl_t;

    ctl_t q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero),
        .pc_en(pc_en), .ir_en(ir_en), .mem_we(mem_we), .rf_we(rf_we),
        .reg_dst(reg_dst), .wd_sel(wd_sel), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .ALUOp(ALUOp), .ext_op(ext_op),
        .npc_sel(npc_sel), .illegal(illegal), .state(state)
    );

    function automatic ctl_t blank(input logic [3:0] st);
        ctl_t c;
        c = '0;
        c.st = st;
        return c;
    endfunction

    function automatic ctl_t e_fetch();
        ctl_t c;
        c = blank(4'd0); c.pc_en = 1'b1; c.ir_en = 1'b1; c.b = 2'd1;
        return c;
    endfunction

    function automatic ctl_t e_decode(input logic ill);
        ctl_t c;
        c = blank(4'd1); c.b = 2'd3; c.ext = 2'd1; c.ill = ill;
        return c;
    endfunction

    function automatic ctl_t e_exec_r(input logic [2:0] op);
        ctl_t c;
        c = blank(4'd2); c.a = 1'b1; c.aluop = op;
        return c;
    endfunction

    function automatic ctl_t e_exec_i(input logic [1:0] ext);
        ctl_t c;
        c = blank(4'd3); c.a = 1'b1; c.b = 2'd2; c.aluop = 3'b011; c.ext = ext;
        return c;
    endfunction

    function automatic ctl_t e_mem_addr();
        ctl_t c;
        c = blank(4'd4); c.a = 1'b1; c.b = 2'd2; c.ext = 2'd1;
        return c;
    endfunction

    function automatic ctl_t e_mem_wb(input logic we);
        ctl_t c;
        c = blank(4'd6); c.rf_we = we; c.wd_sel = 2'd1;
        return c;
    endfunction

    function automatic ctl_t e_mem_wr();
        ctl_t c;
        c = blank(4'd7); c.mem_we = 1'b1;
        return c;
    endfunction

    function automatic ctl_t e_alu_wb(input logic [1:0] rd);
        ctl_t c;
        c = blank(4'd8); c.rf_we = 1'b1; c.reg_dst = rd;
        return c;
    endfunction

    function automatic ctl_t e_branch(input logic z);
        ctl_t c;
        c = blank(4'd9); c.a = 1'b1; c.aluop = 3'b001; c.npc = 2'd1; c.pc_en = z;
        return c;
    endfunction

    function automatic ctl_t e_jump();
        ctl_t c;
        c = blank(4'd10); c.pc_en = 1'b1; c.npc = 2'd2;
        return c;
    endfunction

    function automatic ctl_t observed();
        ctl_t c;
        c = {state, pc_en, ir_en, mem_we, rf_we, reg_dst, wd_sel, alu_src_a,
             alu_src_b, ALUOp, ext_op, npc_sel, illegal};
        return c;
    endfunction

    task automatic check_ctl(input string tag, input ctl_t exp);
        ctl_t o;
        o = observed();
        checks++;
        assert (o === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (state %0d vs %0d)", tag, o, exp, o.st, exp.st);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drains the queue one cycle per entry; the queue length bounds the run.
    task automatic run(input string tag, input logic [31:0] ins, input logic z);
        ctl_t e;
        int   cyc;
        cyc = 0;
        while (q.size() > 0) begin
            @(negedge clk);
            instr = ins;
            zero  = z;
            #1;
            e = q.pop_front();
            check_ctl($sformatf("%s_c%0d", tag, cyc), e);
            cyc++;
        end
    endtask

    task automatic do_rtype(input string tag, input logic [5:0] funct, input logic [2:0] op);
        q.push_back(e_fetch());
        q.push_back(e_decode(1'b0));
        q.push_back(e_exec_r(op));
        q.push_back(e_alu_wb(2'd1));
        run(tag, 32'h0085_1000 | {26'd0, funct}, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        instr = 32'h0;
        zero  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_bit($sformatf("rst%0d_state0", i), (state == 4'd0), 1'b1);
            check_bit($sformatf("rst%0d_rf_we", i), rf_we, 1'b0);
            check_bit($sformatf("rst%0d_mem_we", i), mem_we, 1'b0);
        end
        @(posedge clk);
        #1 reset = 1'b0;

        do_rtype("addu", 6'b100001, 3'b000);
        do_rtype("subu", 6'b100011, 3'b001);
        do_rtype("and",  6'b100100, 3'b010);
        do_rtype("or",   6'b100101, 3'b011);
        do_rtype("srlv", 6'b000110, 3'b100);
        do_rtype("srav", 6'b000111, 3'b101);

        q.push_back(e_fetch()); q.push_back(e_decode(1'b0));
        q.push_back(e_exec_i(2'd0)); q.push_back(e_alu_wb(2'd0));
        run("ori", 32'h3482_ABCD, 1'b0);

        q.push_back(e_fetch()); q.push_back(e_decode(1'b0));
        q.push_back(e_exec_i(2'd2)); q.push_back(e_alu_wb(2'd0));
        run("lui", 32'h3C02_1234, 1'b0);

        q.push_back(e_fetch()); q.push_back(e_decode(1'b0)); q.push_back(e_mem_addr());
        q.push_back(blank(4'd5)); q.push_back(e_mem_wb(1'b1));
        run("lw", 32'h8C82_0004, 1'b0);

        q.push_back(e_fetch()); q.push_back(e_decode(1'b0));
        q.push_back(e_mem_addr()); q.push_back(e_mem_wr());
        run("sw", 32'hAC82_0004, 1'b0);

        q.push_back(e_fetch()); q.push_back(e_decode(1'b0)); q.push_back(e_branch(1'b1));
        run("beq_taken", 32'h1085_0003, 1'b1);

        q.push_back(e_fetch()); q.push_back(e_decode(1'b0)); q.push_back(e_branch(1'b0));
        run("beq_not", 32'h1085_0003, 1'b0);

        q.push_back(e_fetch()); q.push_back(e_decode(1'b0)); q.push_back(e_jump());
        run("j", 32'h0800_0010, 1'b0);

        q.push_back(e_fetch()); q.push_back(e_decode(1'b1));
        run("ill_op", 32'hFC00_0000, 1'b0);

        q.push_back(e_fetch()); q.push_back(e_decode(1'b1));
        run("ill_funct", 32'h0085_102A, 1'b0);

        // lw interrupted by reset in its writeback cycle
        q.push_back(e_fetch()); q.push_back(e_decode(1'b0));
        q.push_back(e_mem_addr()); q.push_back(blank(4'd5));
        run("lw_abort", 32'h8C82_0004, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_ctl("lw_abort_wb", e_mem_wb(1'b0));
        @(posedge clk);
        #1 reset = 1'b0;

        q.push_back(e_fetch()); q.push_back(e_decode(1'b0)); q.push_back(e_jump());
        q.push_back(e_fetch());
        run("after_abort", 32'h0800_0010, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multicycle MIPS control FSM that sequences fetch, decode, execute, memory and writeback for the P-series datapath. It is the producer side of the ALU interface: each cycle it issues the 3-bit ALUOp and operand selects the ALU consumes. It also drives all PC, IR, register-file and memory enables. It uses the ALU zero indication to resolve beq.

Parameters:
none (opcode/funct encodings and ALUOp encoding fixed below)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high; forces state FETCH
instr  in  32  IR contents; valid from DECODE onward (IR loads at end of FETCH)
zero  in  1  ALU result == 0, valid in BRANCH cycle
pc_en  out  1  PC register write enable
ir_en  out  1  IR write enable
mem_we  out  1  data memory write enable
rf_we  out  1  register file write enable
reg_dst  out  2  write reg: 0=rt, 1=rd
wd_sel  out  2  RF write data: 0=ALUOut, 1=MDR
alu_src_a  out  1  0=PC, 1=rs data
alu_src_b  out  2  0=rt data, 1=const 4, 2=ext imm, 3=ext imm<<2
ALUOp  out  3  000 add, 001 sub, 010 and, 011 or, 100 logical right shift, 101 arithmetic right shift
ext_op  out  2  0=zero-ext, 1=sign-ext, 2=imm<<16
npc_sel  out  2  0=ALU result (PC+4), 1=ALUOut (branch target), 2=jump target {PC[31:28],instr[25:0],00}
illegal  out  1  one-cycle pulse in DECODE for an unsupported encoding
state  out  4  current state, for debug and bench

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
  - On reset, state=FETCH(0).
  - All enables (pc_en, ir_en, mem_we, rf_we) and illegal are combinational from state. The FETCH values below are the outputs seen directly after reset.
  - Reset asserted mid-instruction aborts it at the next edge. No RF or memory write occurs in the reset cycle: enables are gated by !reset.
- Outputs are Moore on state, plus decode of instr where noted. Any select not listed for a state = 0; ALUOp defaults to 000.
- Supported instructions:
  - R-type (op 000000), by funct: addu 100001, subu 100011, and 100100, or 100101, srlv 000110, srav 000111.
  - I-type: ori 001101, lui 001111, lw 100011, sw 101011.
  - Branch/jump: beq 000100, j 000010.
- States and outputs:
  - FETCH(0): ir_en=1, pc_en=1, alu_src_a=0, alu_src_b=1, ALUOp=000, npc_sel=0. Next DECODE.
  - DECODE(1): alu_src_a=0, alu_src_b=3, ext_op=1, ALUOp=000; this precomputes the branch target into ALUOut.
    - Next by opcode: R-type→EXEC_R; ori/lui→EXEC_I; lw/sw→MEM_ADDR; beq→BRANCH; j→JUMP.
    - Unsupported op, or unsupported funct with op 000000 → FETCH with illegal=1; the instruction is treated as nop with PC already +4.
  - EXEC_R(2): alu_src_a=1, alu_src_b=0, ALUOp from funct (addu 000, subu 001, and 010, or 011, srlv 100, srav 101). Next ALU_WB.
  - EXEC_I(3): alu_src_a=1, alu_src_b=2. ori: ext_op=0, ALUOp=011. lui: ext_op=2, ALUOp=011, rs=$0 by encoding. Next ALU_WB.
  - MEM_ADDR(4): alu_src_a=1, alu_src_b=2, ext_op=1, ALUOp=000. Next MEM_RD for lw, MEM_WR for sw.
  - MEM_RD(5): memory read, MDR latched externally. Next MEM_WB.
  - MEM_WB(6): rf_we=1, reg_dst=0, wd_sel=1. Next FETCH.
  - MEM_WR(7): mem_we=1. Next FETCH.
  - ALU_WB(8): rf_we=1, wd_sel=0, reg_dst=1 for R-type, 0 for I-type. Next FETCH.
  - BRANCH(9): alu_src_a=1, alu_src_b=0, ALUOp=001, npc_sel=1, pc_en=zero. Next FETCH.
  - JUMP(10): pc_en=1, npc_sel=2. Next FETCH.
  - Codes 11–15 → FETCH next cycle, all enables 0.
- Cycles per instruction (FETCH through last state): R-type 4, ori/lui 4, lw 5, sw 4, beq 3, j 3, illegal 2.
- Exactly one pc_en pulse per FETCH, plus at most one more in BRANCH/JUMP. ir_en is asserted only in FETCH.
- The decision is made on instr in DECODE. The path taken depends only on op/funct; rs/rt/rd fields do not affect control.

Test Plan:
- Reset held 3 cycles, then released → state=0, ir_en=pc_en=1, rf_we=mem_we=0 in the first post-reset cycle; state=1 on the next cycle.
- instr=0x00851021 (addu $2,$4,$5) → states 0,1,2,8; ALUOp=000 in state 2; rf_we=1 with reg_dst=1 only in state 8. Repeat for subu 001, and 010, or 011, srlv 100, srav 101.
- instr=0x8C820004 (lw) → states 0,1,4,5,6, ext_op=1 in state 4, wd_sel=1 and rf_we=1 in state 6. instr=0xAC820004 (sw) → states 0,1,4,7, mem_we=1 only in state 7.
- beq 0x10850003: with zero=1 → pc_en=1 and npc_sel=1 in state 9; with zero=0 → pc_en=0. j 0x08000010 → state 10 with pc_en=1 and npc_sel=2.
- instr=0xFC000000 → illegal=1 for one cycle in state 1, then state 0. No rf_we or mem_we asserted during the instruction.
- reset asserted while in state 6 (lw writeback) → rf_we=0 that cycle, state=0 next cycle.
